axi4_pchase: RTL and testbench

- AXI4 read-only master that runs a pointer-chasing memory latency benchmark.
- Starting from a given address, it reads one 512-bit beat per hop and takes the next address from the low 64 bits of the returned data, for a programmed number of hops.
- Reports the total clock cycles spent.
- Sits between an HLS-style ap_start/ap_done control interface and a 512-bit AXI4 memory port.

---
 rtl/axi4_pchase_if.sv | 27 ++
 rtl/axi4_pchase.sv | 124 ++++++++++++
 tb/tb_axi4_pchase.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_pchase_if.sv
// AXI4 read-channel bundle for the pointer-chase master.
// The master modport is the DUT side and the slave modport is the memory side.
interface axi4_pchase_if;
  logic         arvalid;
  logic         arready;
  logic [63:0]  araddr;
  logic         arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [511:0] rdata;
  logic         rid;
  logic [1:0]   rresp;
  logic         rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/axi4_pchase.sv
// AXI4 read-only pointer-chasing latency benchmark.
// Each hop reads one 512-bit beat. The next hop address is taken from rdata[63:0].
// The cycles spent in the AR and R phases are counted.
// Optional macro PCHASE_ALIGN_EN forces every pointer, including the start address,
// to a 64-byte boundary.
module axi4_pchase (
  input  logic                 clk,
  input  logic                 reset,
  axi4_pchase_if.master        io_axi,
  input  logic [63:0]          io_start_addr,
  input  logic [31:0]          io_num_burst,
  output logic [31:0]          io_cnt_clk,
  input  logic                 io_ap_start,
  output logic                 io_ap_ready,
  output logic                 io_ap_done,
  output logic                 io_ap_idle
);

  typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_t;

  state_t      state;
  logic        arvalid;
  logic        rready;
  logic [63:0] araddr;
  logic [31:0] remaining;
  logic [31:0] cnt_clk;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;

  // Response fields and the upper data bits play no part in the chase.
  logic unused_inputs;
  assign unused_inputs = ^{io_axi.rid, io_axi.rresp, io_axi.rdata[511:64]};

  function automatic logic [63:0] fix_ptr(input logic [63:0] p);
`ifdef PCHASE_ALIGN_EN
    return {p[63:6], 6'b0};
`else
    return p;
`endif
  endfunction

  // Drive the AR fields and the control outputs. The constant AR fields are driven
  // whether or not arvalid is high.
  assign io_axi.arvalid = arvalid;
  assign io_axi.araddr  = araddr;
  assign io_axi.arid    = 1'b0;
  assign io_axi.arlen   = 8'd0;
  assign io_axi.arsize  = 3'b110;
  assign io_axi.arburst = 2'b01;
  assign io_axi.rready  = rready;
  assign io_cnt_clk     = cnt_clk;
  assign io_ap_ready    = ap_ready;
  assign io_ap_done     = ap_done;
  assign io_ap_idle     = ap_idle;

  // Control FSM. Every output is registered. At most one read is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      araddr    <= '0;
      remaining <= '0;
      cnt_clk   <= '0;
      ap_ready  <= 1'b0;
      ap_done   <= 1'b0;
      ap_idle   <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (io_ap_start) begin
            araddr    <= fix_ptr(io_start_addr);
            remaining <= io_num_burst;
            cnt_clk   <= '0;
            ap_idle   <= 1'b0;
            if (io_num_burst == 32'd0) begin
              state    <= StDone;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
            end else begin
              state   <= StAr;
              arvalid <= 1'b1;
            end
          end
        end
        StAr: begin
          cnt_clk <= cnt_clk + 32'd1;
          // arvalid is always high in this state, so arready alone completes the handshake.
          if (io_axi.arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= StR;
          end
        end
        StR: begin
          cnt_clk <= cnt_clk + 32'd1;
          // A beat without rlast is accepted and discarded.
          if (io_axi.rvalid && io_axi.rlast) begin
            araddr    <= fix_ptr(io_axi.rdata[63:0]);
            remaining <= remaining - 32'd1;
            rready    <= 1'b0;
            if (remaining == 32'd1) begin
              state    <= StDone;
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
            end else begin
              state   <= StAr;
              arvalid <= 1'b1;
            end
          end
        end
        StDone: begin
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          ap_idle  <= 1'b1;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_pchase.sv
// Self-checking bench for axi4_pchase. A memory slave answers with either fixed or
// random delays. The expected results come from walking the bench's own pointer map.
module tb_axi4_pchase;
  logic        clk;
  logic        reset;
  logic [63:0] io_start_addr;
  logic [31:0] io_num_burst;
  logic [31:0] io_cnt_clk;
  logic        io_ap_start;
  logic        io_ap_ready;
  logic        io_ap_done;
  logic        io_ap_idle;

  axi4_pchase_if axi();

  axi4_pchase dut (
    .clk           (clk),
    .reset         (reset),
    .io_axi        (axi),
    .io_start_addr (io_start_addr),
    .io_num_burst  (io_num_burst),
    .io_cnt_clk    (io_cnt_clk),
    .io_ap_start   (io_ap_start),
    .io_ap_ready   (io_ap_ready),
    .io_ap_done    (io_ap_done),
    .io_ap_idle    (io_ap_idle)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem [logic [63:0]];
  logic [63:0] ar_q [$];
  logic [31:0] exp_cyc;
  int          fix_ar = -1;
  int          fix_r  = -1;
  int          unstable = 0;
  int          const_bad = 0;
  logic        slave_busy = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] align(input logic [63:0] p);
`ifdef PCHASE_ALIGN_EN
    return {p[63:6], 6'b0};
`else
    return p;
`endif
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Memory slave. Each hop costs (AR wait + 1) + (R wait + 1) + any extra non-last beat.
  initial begin
    int dar, dr, extra;
    logic [63:0] a0, ptr;
    logic [511:0] d;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    axi.rdata = '0; axi.rid = 1'b0; axi.rresp = 2'b00;
    forever begin
      @(negedge clk);
      while (axi.arvalid && reset) begin
        slave_busy = 1'b1;
        dar   = (fix_ar >= 0) ? fix_ar : int'($urandom_range(0, 3));
        dr    = (fix_r >= 0) ? fix_r : int'($urandom_range(0, 4));
        extra = (fix_r >= 0) ? 0 : int'($urandom_range(0, 1));
        a0 = axi.araddr;
        if (axi.arlen !== 8'd0 || axi.arsize !== 3'b110 || axi.arburst !== 2'b01 ||
            axi.arid !== 1'b0) const_bad++;
        for (int i = 0; i < dar; i++) begin
          @(negedge clk);
          if (axi.araddr !== a0 || axi.arvalid !== 1'b1) unstable++;
        end
        axi.arready = 1'b1;
        ar_q.push_back(axi.araddr);
        ptr = mem.exists(axi.araddr) ? mem[axi.araddr] : {$urandom, $urandom};
        @(negedge clk);
        axi.arready = 1'b0;
        repeat (dr) @(negedge clk);
        if (extra != 0) begin
          axi.rvalid = 1'b1; axi.rlast = 1'b0; axi.rdata = rand512();
          @(negedge clk);
        end
        exp_cyc += 32'(dar + dr + extra + 2);
        d = rand512();
        d[63:0] = ptr;
        axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = d;
        axi.rresp = 2'($urandom_range(0, 3)); axi.rid = 1'($urandom_range(0, 1));
        @(negedge clk);
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        slave_busy = 1'b0;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, " arvalid"}, 64'(axi.arvalid), 64'd0);
    check({tag, " rready"},  64'(axi.rready), 64'd0);
    check({tag, " araddr"},  axi.araddr, 64'd0);
    check({tag, " cnt"},     64'(io_cnt_clk), 64'd0);
    check({tag, " ready"},   64'(io_ap_ready), 64'd0);
    check({tag, " done"},    64'(io_ap_done), 64'd0);
    check({tag, " idle"},    64'(io_ap_idle), 64'd1);
  endtask

  task automatic wait_slave_idle(input string tag);
    int w = 0;
    while (slave_busy && w < 500) begin @(negedge clk); w++; end
    check({tag, " slave idle"}, 64'(slave_busy), 64'd0);
  endtask

  // Build a chain of n random hops from start into mem.
  task automatic make_chain(input logic [63:0] start, input int n);
    logic [63:0] p = start;
    logic [63:0] nx;
    for (int i = 0; i < n; i++) begin
      nx = {$urandom, $urandom};
      mem[align(p)] = nx;
      p = nx;
    end
  endtask

  // Run one benchmark and compare it with the model walk over mem.
  task automatic run(input logic [63:0] start, input int n, input string tag,
                     output logic [31:0] cnt_out, output logic [63:0] final_out);
    logic [63:0] a;
    logic [63:0] exp_q [$];
    int w;
    wait_slave_idle(tag);
    ar_q.delete(); exp_cyc = '0; unstable = 0; const_bad = 0;
    io_start_addr = start; io_num_burst = 32'(n); io_ap_start = 1'b1;
    @(negedge clk);
    io_ap_start = 1'b0;
    w = 0;
    while (!io_ap_done && w < 3000) begin @(negedge clk); w++; end
    check({tag, " done"},  64'(io_ap_done), 64'd1);
    check({tag, " ready"}, 64'(io_ap_ready), 64'd1);
    a = align(start);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = align(mem[a]);
    end
    check({tag, " ar count"}, 64'(ar_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ar_q.size(); i++)
      check({tag, " ar addr"}, ar_q[i], exp_q[i]);
    check({tag, " final araddr"}, axi.araddr, a);
    check({tag, " cnt"}, 64'(io_cnt_clk), 64'(exp_cyc));
    check({tag, " ar stable"}, 64'(unstable), 64'd0);
    check({tag, " ar consts"}, 64'(const_bad), 64'd0);
    cnt_out = io_cnt_clk;
    final_out = axi.araddr;
    @(negedge clk);
    check({tag, " done drop"}, 64'(io_ap_done), 64'd0);
    check({tag, " ready drop"}, 64'(io_ap_ready), 64'd0);
    check({tag, " idle back"}, 64'(io_ap_idle), 64'd1);
    check({tag, " cnt hold"}, 64'(io_cnt_clk), 64'(cnt_out));
  endtask

  initial begin
    logic [31:0] c;
    logic [63:0] f;
    logic [63:0] s;
    int w;
    reset = 1'b0; io_ap_start = 1'b0; io_start_addr = '0; io_num_burst = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    check("reset arsize", 64'(axi.arsize), 64'd6);
    check("reset arburst", 64'(axi.arburst), 64'd1);
    reset = 1'b1;
    @(negedge clk);

    // Single hop: data comes back 3 cycles after the AR handshake.
    fix_ar = 0; fix_r = 3;
    mem[align(64'h1000)] = 64'h2000;
    run(64'h1000, 1, "single", c, f);
    check("single cnt abs", 64'(c), 64'd5);
    check("single final abs", f, 64'h2000);

    // Chain of 4 hops.
    fix_ar = 0; fix_r = 0;
    mem[64'h0] = 64'h40; mem[64'h40] = 64'h80; mem[64'h80] = 64'hC0; mem[64'hC0] = 64'h100;
    run(64'h0, 4, "chain4", c, f);
    check("chain4 final abs", f, 64'h100);
    check("chain4 cnt abs", 64'(c), 64'd8);

    // Backpressure on both channels.
    fix_ar = 5; fix_r = 10;
    mem[64'h5000] = 64'h6000; mem[64'h6000] = 64'h7000;
    run(64'h5000, 2, "stall", c, f);
    check("stall cnt abs", 64'(c), 64'd34);

    // Zero hops.
    fix_ar = -1; fix_r = -1;
    run(64'hABC0, 0, "zero", c, f);
    check("zero cnt abs", 64'(c), 64'd0);

    // Unaligned pointer.
    mem[align(64'h3000)] = 64'h1234;
    run(64'h3000, 1, "unalign", c, f);
`ifdef PCHASE_ALIGN_EN
    check("unalign ptr", f, 64'h1200);
`else
    check("unalign ptr", f, 64'h1234);
`endif

    // Random chains and random slave timing.
    for (int r = 0; r < 5; r++) begin
      int n = int'($urandom_range(1, 6));
      s = {$urandom, $urandom};
      make_chain(s, n);
      run(s, n, "random", c, f);
    end

    // Reset while a read response is outstanding.
    fix_ar = 0; fix_r = 20;
    wait_slave_idle("rst");
    mem[64'h9000] = 64'h9100; mem[64'h9100] = 64'h9200; mem[64'h9200] = 64'h9300;
    io_start_addr = 64'h9000; io_num_burst = 32'd3; io_ap_start = 1'b1;
    @(negedge clk);
    io_ap_start = 1'b0;
    w = 0;
    while (!axi.rready && w < 100) begin @(negedge clk); w++; end
    check("rst reached R", 64'(axi.rready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_slave_idle("midrst");
    check("midrst araddr after drop", axi.araddr, 64'd0);
    fix_ar = -1; fix_r = -1;
    s = {$urandom, $urandom};
    make_chain(s, 3);
    run(s, 3, "post rst", c, f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
